// File: rtl/aes_inv_key_sched_ctrl.sv
// Sequencer for the AES-128 inverse key expander: presents the latched round-NR key,
// then steps the expander backwards to deliver keys NR..0 over a valid/ready handshake.
module aes_inv_key_sched_ctrl #(
    parameter int KEY_W = 128,
    parameter int NR    = 10,
    parameter int RW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [KEY_W-1:0] key_last_i,
    input  logic             abort_i,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [KEY_W-1:0] rk_data_o,
    output logic [RW-1:0]    rk_round_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [KEY_W-1:0] exp_key_last_o,
    output logic             exp_begin_round_o,
    output logic             exp_rkey_en_o,
    output logic [RW-1:0]    exp_round_num_o,
    input  logic [KEY_W-1:0] exp_round_key_i
);

    localparam logic [RW-1:0] NR_R   = RW'(NR);
    localparam logic [RW-1:0] ZERO_R = {RW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GEN  = 2'd2
    } state_e;

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic [RW-1:0]    rk_round_q;
    logic             rk_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             exp_begin_q;
    logic             exp_rken_q;
    logic [RW-1:0]    exp_round_num_q;

    // Sequencer state, handshake flags and expander controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            key_q           <= {KEY_W{1'b0}};
            rk_round_q      <= ZERO_R;
            rk_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            exp_begin_q     <= 1'b0;
            exp_rken_q      <= 1'b0;
            exp_round_num_q <= ZERO_R;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A simultaneous abort suppresses the start.
                    if (start_i && !abort_i) begin
                        key_q      <= key_last_i;
                        rk_round_q <= NR_R;
                        rk_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND: begin
                    if (abort_i) begin
                        state_q    <= IDLE;
                        rk_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        rk_round_q <= ZERO_R;
                    end else if (rk_ready_i) begin
                        rk_valid_q <= 1'b0;
                        if (rk_round_q == ZERO_R) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // Round NR is derived from key_last; later rounds step the register.
                            state_q         <= GEN;
                            exp_round_num_q <= rk_round_q;
                            if (rk_round_q == NR_R) begin
                                exp_begin_q <= 1'b1;
                                exp_rken_q  <= 1'b0;
                            end else begin
                                exp_begin_q <= 1'b0;
                                exp_rken_q  <= 1'b1;
                            end
                        end
                    end else begin
                        state_q <= SEND;
                    end
                end
                GEN: begin
                    exp_begin_q     <= 1'b0;
                    exp_rken_q      <= 1'b0;
                    exp_round_num_q <= ZERO_R;
                    if (abort_i) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        rk_round_q <= ZERO_R;
                    end else begin
                        state_q    <= SEND;
                        rk_valid_q <= 1'b1;
                        rk_round_q <= rk_round_q - {{(RW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    rk_valid_q      <= 1'b0;
                    busy_q          <= 1'b0;
                    exp_begin_q     <= 1'b0;
                    exp_rken_q      <= 1'b0;
                    exp_round_num_q <= ZERO_R;
                    rk_round_q      <= ZERO_R;
                end
            endcase
        end
    end

    // Round NR comes straight from the latch; all others from the expander register.
    always_comb begin
        rk_data_o = exp_round_key_i;
        if (rk_round_q == NR_R) begin
            rk_data_o = key_q;
        end else begin
            rk_data_o = exp_round_key_i;
        end
    end

    assign rk_valid_o        = rk_valid_q;
    assign rk_round_o        = rk_round_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign exp_key_last_o    = key_q;
    assign exp_begin_round_o = exp_begin_q;
    assign exp_rkey_en_o     = exp_rken_q;
    assign exp_round_num_o   = exp_round_num_q;

endmodule

// File: doc/aes_inv_key_sched_ctrl.md
Name: aes_inv_key_sched_ctrl

Overview:
- Sequencer for the AES-128 inverse key expander. It latches the round-10 key and presents it first.
- It then steps the expander backwards one round at a time, delivering round keys 10, 9, …, 0 to the decryption round datapath over a valid/ready handshake.
- It owns the expander's begin_round, rkey_en and round_num controls. It sits between the key-load interface and the inverse cipher round controller.

Parameters:
- KEY_W, 128, round key width in bits.
- NR, 10, number of rounds; first key index presented = NR, last = 0.
- RW, 4, width of round index signals; must satisfy 2^RW > NR.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a key sequence; sampled only in IDLE
- key_last  in  KEY_W  round-NR key, sampled on the cycle start is accepted
- abort  in  1  synchronous abort of the sequence in progress
- rk_valid  out  1  rk_data/rk_round hold a valid round key
- rk_ready  in  1  consumer accepts the key; transfer occurs when rk_valid&rk_ready
- rk_data  out  KEY_W  round key presented
- rk_round  out  RW  index of the presented key (NR down to 0)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after round-0 key transfer
- exp_key_last  out  KEY_W  latched round-NR key, fed to the expander's round_key_10 input
- exp_begin_round  out  1  expander begin_round
- exp_rkey_en  out  1  expander rkey_en
- exp_round_num  out  RW  expander round_num
- exp_round_key  in  KEY_W  expander registered output key

Behaviour:
- Reset (rst_n=0, async): state=IDLE; rk_valid, busy, done, exp_begin_round and exp_rkey_en = 0; rk_round, exp_round_num = 0; key latch = 0.
- States are IDLE, SEND, GEN.
- IDLE:
  - When start=1, latch key_last into key_q and set rk_round=NR; next state SEND.
  - start is ignored in every other state.
- SEND:
  - rk_valid=1.
  - rk_data = key_q when rk_round==NR, else exp_round_key.
  - rk_data and rk_round are held stable while rk_ready=0.
  - On transfer with rk_round==0: done=1 on the following cycle; next state IDLE.
  - On transfer with rk_round>0: next state GEN.
- GEN lasts exactly one cycle with rk_valid=0:
  - exp_round_num = rk_round, i.e. the source key index.
  - If rk_round==NR: exp_begin_round=1, exp_rkey_en=0.
  - Otherwise: exp_rkey_en=1, exp_begin_round=0.
  - rk_round decrements by 1; next state SEND.
  - The expander register updates on the GEN→SEND edge, so exp_round_key is valid in SEND.
- Outside GEN, exp_begin_round and exp_rkey_en are both 0.
  - They are never both 1, because the expander loads on their XOR.
- exp_key_last = key_q at all times.
- Latency:
  - start accepted at cycle t → rk_valid at t+1 with round NR.
  - Transfer at cycle t → next key valid at t+2, giving 1 bubble per round.
  - Minimum sequence with rk_ready tied high: 1 + (NR+1) + NR = 22 cycles start-to-done.
- abort=1 in any non-IDLE state:
  - Next state IDLE; rk_valid=0; expander controls 0; no done pulse.
  - abort has priority over a simultaneous transfer.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start is ignored.
- done pulses for exactly one cycle, coinciding with the first IDLE cycle. start in that cycle is accepted.
- rk_round never underflows: no GEN is issued from round 0.
- Async reset mid-sequence returns to IDLE immediately; the expander register content is don't-care afterwards.

Test Plan:
- FIPS-197 key 2b7e1516…09cf4f3c, key_last=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 → round 10 key at cycle 1 = d014f9a8…; 10 later keys match the forward schedule in reverse, ending with rk_round=0, rk_data=2b7e151628aed2a6abf7158809cf4f3c; done at cycle 22.
- Same run, check controls → exp_begin_round=1 only in the first GEN (exp_round_num=10); exp_rkey_en=1 in the 9 later GENs (exp_round_num 9…1); never both high.
- rk_ready low for 5 cycles while rk_round=7 → rk_valid stays 1; rk_data and rk_round stable; no GEN issued until ready.
- abort asserted in the SEND cycle of round 4 while rk_ready=1 → state IDLE next cycle, no transfer counted, done never pulses; a following start restarts at round 10 with the correct key.
- start pulsed while busy and in the done cycle → ignored while busy; accepted in the done cycle, with rk_valid for round 10 on the next cycle.
- rst_n dropped mid-GEN → all outputs at reset values asynchronously; after release, a start gives a clean full sequence.
